// File: rtl/sd_spi_card_responder.sv
// sd_spi_card_responder
// Card-side end of the SD SPI-mode command interface. Oversamples SCLK/CS/DI on
// clk (clk >= 8x SCLK), deframes 48-bit commands and answers with R1/R7 on DO,
// modelling the CMD0 -> CMD8 -> (CMD55, ACMD41)* power-up sequence.
// Optional feature macro: SD_SPI_RESPONDER_CRC_CHECK_EN (CRC7 check on CMD0/CMD8).
module sd_spi_card_responder #(
  parameter int NCR_BYTES  = 1,
  parameter int INIT_POLLS = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SCLK,
  input  logic        CS,
  input  logic        DI,
  output logic        DO,
  output logic        isIdle,
  output logic        cmdStrobe,
  output logic [5:0]  cmdIndex,
  output logic [31:0] cmdArgument
);

`ifdef SD_SPI_RESPONDER_CRC_CHECK_EN
  // index + argument + CRC7 are kept when the CRC is checked
  localparam int FIELD_W = 45;
`else
  // only index + argument are kept; the CRC field is never stored
  localparam int FIELD_W = 38;
`endif

  localparam logic [6:0] NCR_BITS   = 7'(NCR_BYTES * 8);
  localparam logic [7:0] POLL_LIMIT = 8'(INIT_POLLS);
  localparam logic [5:0] LAST_FIELD = 6'(FIELD_W + 1);

  typedef enum logic [2:0] {
    ST_HUNT   = 3'd0,
    ST_RECV   = 3'd1,
    ST_DECODE = 3'd2,
    ST_NCR    = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

  // synchronisers
  logic [1:0] sclk_sync_q;
  logic [1:0] cs_sync_q;
  logic [1:0] di_sync_q;
  logic       sclk_prev_q;
  logic       sclk_rise_s;
  logic       sclk_fall_s;
  logic       cs_high_s;
  logic       di_s;

  // protocol state
  state_e               state_q,    state_d;
  logic [5:0]           bit_cnt_q,  bit_cnt_d;
  logic [FIELD_W-1:0]   shift_q,    shift_d;
  logic [39:0]          resp_q,     resp_d;
  logic [5:0]           resp_len_q, resp_len_d;
  logic [6:0]           ncr_cnt_q,  ncr_cnt_d;
  logic                 do_q,       do_d;
  logic                 idle_q,     idle_d;
  logic                 strobe_q,   strobe_d;
  logic [5:0]           index_q,    index_d;
  logic [31:0]          arg_q,      arg_d;
  logic [7:0]           poll_q,     poll_d;
  logic                 app_q,      app_d;

  // decode results for the frame held in shift_q
  logic [5:0]  rx_index_s;
  logic [31:0] rx_arg_s;
  logic        dec_idle_s;
  logic [7:0]  dec_poll_s;
  logic        dec_app_s;
  logic        illegal_s;
  logic        crc_err_s;
  logic [7:0]  r1_s;
  logic [39:0] dec_resp_s;
  logic [5:0]  dec_len_s;

`ifdef SD_SPI_RESPONDER_CRC_CHECK_EN
  // CRC7 (x^7 + x^3 + 1) over the 40 leading frame bits, MSB first
  function automatic logic [6:0] crc7_calc(input logic [39:0] data);
    logic [6:0] crc;
    logic       fb;
    crc = 7'h00;
    for (int i = 39; i >= 0; i--) begin
      fb  = data[i] ^ crc[6];
      crc = {crc[5:0], 1'b0};
      if (fb) begin
        crc = crc ^ 7'h09;
      end else begin
        crc = crc;
      end
    end
    return crc;
  endfunction
`endif

  assign sclk_rise_s = sclk_sync_q[1] & ~sclk_prev_q;
  assign sclk_fall_s = ~sclk_sync_q[1] & sclk_prev_q;
  assign cs_high_s   = cs_sync_q[1];
  assign di_s        = di_sync_q[1];

  // Two-flop synchronisers on the host pins plus SCLK history for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= 2'b00;
      cs_sync_q   <= 2'b11;
      di_sync_q   <= 2'b11;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], SCLK};
      cs_sync_q   <= {cs_sync_q[0], CS};
      di_sync_q   <= {di_sync_q[0], DI};
      sclk_prev_q <= sclk_sync_q[1];
    end
  end

  // Command decode: card-state update and response buffer for the received frame.
  always_comb begin
    rx_index_s = shift_q[FIELD_W-1 -: 6];
    rx_arg_s   = shift_q[FIELD_W-7 -: 32];
    dec_idle_s = idle_q;
    dec_poll_s = poll_q;
    dec_app_s  = 1'b0;
    illegal_s  = 1'b0;
    crc_err_s  = 1'b0;
`ifdef SD_SPI_RESPONDER_CRC_CHECK_EN
    if (((rx_index_s == 6'd0) || (rx_index_s == 6'd8)) &&
        (crc7_calc({2'b01, rx_index_s, rx_arg_s}) != shift_q[6:0])) begin
      crc_err_s = 1'b1;
    end else begin
      crc_err_s = 1'b0;
    end
`endif
    if (crc_err_s) begin
      // a corrupted CMD0/CMD8 leaves the card state untouched
      dec_app_s = app_q;
    end else begin
      case (rx_index_s)
        6'd0: begin
          dec_idle_s = 1'b1;
          dec_poll_s = 8'd0;
        end
        6'd8: begin
          dec_app_s = 1'b0;
        end
        6'd55: begin
          dec_app_s = 1'b1;
        end
        6'd41: begin
          if (!app_q) begin
            illegal_s = 1'b1;
          end else if (poll_q < POLL_LIMIT) begin
            dec_poll_s = poll_q + 8'd1;
          end else begin
            dec_idle_s = 1'b0;
          end
        end
        default: begin
          illegal_s = 1'b1;
        end
      endcase
    end
    r1_s = {4'b0000, crc_err_s, illegal_s, 1'b0, dec_idle_s};
    if (rx_index_s == 6'd8) begin
      dec_resp_s = {r1_s, 8'h00, 8'h00, 4'h0, rx_arg_s[11:8], rx_arg_s[7:0]};
      dec_len_s  = 6'd40;
    end else begin
      dec_resp_s = {r1_s, 32'hFFFF_FFFF};
      dec_len_s  = 6'd8;
    end
  end

  // Next-state logic: frame hunting, reception, decode, NCR gap and response shift.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    resp_d     = resp_q;
    resp_len_d = resp_len_q;
    ncr_cnt_d  = ncr_cnt_q;
    do_d       = do_q;
    idle_d     = idle_q;
    strobe_d   = 1'b0;
    index_d    = index_q;
    arg_d      = arg_q;
    poll_d     = poll_q;
    app_d      = app_q;

    if (cs_high_s) begin
      // deselect aborts whatever is in flight
      state_d   = ST_HUNT;
      bit_cnt_d = 6'd0;
      do_d      = 1'b1;
    end else begin
      case (state_q)
        ST_HUNT: begin
          if (sclk_rise_s && !di_s) begin
            state_d   = ST_RECV;
            bit_cnt_d = 6'd1;
          end else begin
            state_d = ST_HUNT;
          end
        end
        ST_RECV: begin
          if (sclk_rise_s) begin
            bit_cnt_d = bit_cnt_q + 6'd1;
            if (bit_cnt_q == 6'd1) begin
              // transmission bit must be 1
              if (!di_s) begin
                state_d = ST_HUNT;
              end else begin
                state_d = ST_RECV;
              end
            end else if (bit_cnt_q == 6'd47) begin
              // end bit must be 1
              if (di_s) begin
                state_d = ST_DECODE;
              end else begin
                state_d = ST_HUNT;
              end
            end else if (bit_cnt_q <= LAST_FIELD) begin
              shift_d = {shift_q[FIELD_W-2:0], di_s};
            end else begin
              shift_d = shift_q;
            end
          end else begin
            state_d = ST_RECV;
          end
        end
        ST_DECODE: begin
          strobe_d   = 1'b1;
          index_d    = rx_index_s;
          arg_d      = rx_arg_s;
          idle_d     = dec_idle_s;
          poll_d     = dec_poll_s;
          app_d      = dec_app_s;
          resp_d     = dec_resp_s;
          resp_len_d = dec_len_s;
          ncr_cnt_d  = 7'd0;
          state_d    = ST_NCR;
        end
        ST_NCR: begin
          if (sclk_fall_s) begin
            if (ncr_cnt_q == NCR_BITS) begin
              // this falling edge ends the last filler bit
              do_d      = resp_q[39];
              resp_d    = {resp_q[38:0], 1'b1};
              bit_cnt_d = 6'd1;
              state_d   = ST_RESP;
            end else begin
              ncr_cnt_d = ncr_cnt_q + 7'd1;
            end
          end else begin
            state_d = ST_NCR;
          end
        end
        ST_RESP: begin
          if (sclk_fall_s) begin
            if (bit_cnt_q == resp_len_q) begin
              do_d      = 1'b1;
              bit_cnt_d = 6'd0;
              state_d   = ST_HUNT;
            end else begin
              do_d      = resp_q[39];
              resp_d    = {resp_q[38:0], 1'b1};
              bit_cnt_d = bit_cnt_q + 6'd1;
            end
          end else begin
            state_d = ST_RESP;
          end
        end
        default: begin
          state_d   = ST_HUNT;
          bit_cnt_d = 6'd0;
          do_d      = 1'b1;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_HUNT;
      bit_cnt_q  <= 6'd0;
      shift_q    <= '0;
      resp_q     <= 40'hFF_FFFF_FFFF;
      resp_len_q <= 6'd8;
      ncr_cnt_q  <= 7'd0;
      do_q       <= 1'b1;
      idle_q     <= 1'b1;
      strobe_q   <= 1'b0;
      index_q    <= 6'd0;
      arg_q      <= 32'd0;
      poll_q     <= 8'd0;
      app_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      resp_q     <= resp_d;
      resp_len_q <= resp_len_d;
      ncr_cnt_q  <= ncr_cnt_d;
      do_q       <= do_d;
      idle_q     <= idle_d;
      strobe_q   <= strobe_d;
      index_q    <= index_d;
      arg_q      <= arg_d;
      poll_q     <= poll_d;
      app_q      <= app_d;
    end
  end

  assign DO          = do_q;
  assign isIdle      = idle_q;
  assign cmdStrobe   = strobe_q;
  assign cmdIndex    = index_q;
  assign cmdArgument = arg_q;

endmodule

// File: tb/tb_sd_spi_card_responder.sv
// tb_sd_spi_card_responder
// Host-side SPI driver plus a byte-level card model; directed power-up sequence,
// abort cases and randomised command traffic.
module tb_sd_spi_card_responder;

  localparam int NCR   = 2;
  localparam int POLLS = 2;
`ifdef SD_SPI_RESPONDER_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        SCLK  = 1'b0;
  logic        CS    = 1'b1;
  logic        DI    = 1'b1;
  logic        DO;
  logic        isIdle;
  logic        cmdStrobe;
  logic [5:0]  cmdIndex;
  logic [31:0] cmdArgument;

  int n_checks = 0;
  int n_err    = 0;

  // card model
  bit          m_idle  = 1'b1;
  int          m_polls = 0;
  bit          m_app   = 1'b0;
  logic [7:0]  exp_b[5];
  int          exp_n   = 1;
  logic [7:0]  got_b[5];
  logic        rx_bit;

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    bit          idle;
  } ev_t;
  ev_t         evq[$];
  ev_t         ev;
  bit          c_idle = 1'b1;
  logic [5:0]  c_idx  = 6'd0;
  logic [31:0] c_arg  = 32'd0;
  int          cs_hi_cnt = 0;
  int          n_strobes = 0;
  int          n_frames  = 0;

  always #5 clk = ~clk;

  sd_spi_card_responder #(.NCR_BYTES(NCR), .INIT_POLLS(POLLS)) dut (
    .clk(clk), .rst_n(rst_n), .SCLK(SCLK), .CS(CS), .DI(DI), .DO(DO),
    .isIdle(isIdle), .cmdStrobe(cmdStrobe), .cmdIndex(cmdIndex), .cmdArgument(cmdArgument)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // CRC7 as polynomial long division of data*x^7 by x^7+x^3+1
  function automatic logic [6:0] ref_crc7(input logic [39:0] d);
    logic [46:0] r;
    r = {d, 7'h00};
    for (int i = 46; i >= 7; i--) begin
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    end
    return r[6:0];
  endfunction

  // Card rules at byte level: update model state, produce expected response bytes.
  task automatic model_cmd(input logic [5:0] idx, input logic [31:0] arg, input bit crc_ok);
    bit         crc_bad;
    bit         illegal;
    logic [7:0] r1;
    crc_bad = CRC_EN && !crc_ok && (idx == 6'd0 || idx == 6'd8);
    illegal = 1'b0;
    if (!crc_bad) begin
      if (idx == 6'd0) begin
        m_idle  = 1'b1;
        m_polls = 0;
      end else if (idx == 6'd41 && m_app) begin
        if (m_polls < POLLS) m_polls++;
        else m_idle = 1'b0;
      end else if (idx != 6'd8 && idx != 6'd55) begin
        illegal = 1'b1;
      end
      m_app = (idx == 6'd55);
    end
    r1 = 8'(m_idle) + (illegal ? 8'h04 : 8'h00) + (crc_bad ? 8'h08 : 8'h00);
    exp_b[0] = r1;
    if (idx == 6'd8) begin
      exp_n    = 5;
      exp_b[1] = 8'h00;
      exp_b[2] = 8'h00;
      exp_b[3] = {4'h0, arg[11:8]};
      exp_b[4] = arg[7:0];
    end else begin
      exp_n = 1;
    end
    evq.push_back('{idx, arg, m_idle});
    n_frames++;
  endtask

  // one SPI mode-0 bit: drive DI, sample DO just before the rising edge
  task automatic xfer(input logic dout, input int half);
    DI = dout;
    repeat (half) @(posedge clk);
    #3;
    rx_bit = DO;
    SCLK = 1'b1;
    repeat (half) @(posedge clk);
    #3;
    SCLK = 1'b0;
  endtask

  task automatic cs_low();
    CS = 1'b0;
    repeat (4) @(posedge clk);
    #3;
  endtask

  task automatic cs_high();
    CS = 1'b1;
    repeat (6) @(posedge clk);
    #3;
  endtask

  function automatic logic [47:0] mk_frame(input logic [5:0] idx, input logic [31:0] arg, input bit zero_crc);
    logic [6:0] c;
    c = zero_crc ? 7'h00 : ref_crc7({2'b01, idx, arg});
    return {2'b01, idx, arg, c, 1'b1};
  endfunction

  task automatic send_bits(input logic [47:0] f, input int nbits, input int half);
    for (int i = 47; i > 47 - nbits; i--) xfer(f[i], half);
  endtask

  task automatic send_frame(input logic [5:0] idx, input logic [31:0] arg, input bit zero_crc, input int half);
    logic [47:0] f;
    f = mk_frame(idx, arg, zero_crc);
    model_cmd(idx, arg, f[7:1] == ref_crc7({2'b01, idx, arg}));
    send_bits(f, 48, half);
  endtask

  // filler bytes then up to max_bits response bits, each complete byte compared
  task automatic read_resp(input int half, input int max_bits);
    logic [7:0] byt;
    byt = 8'h00;
    for (int k = 0; k < NCR * 8; k++) begin
      xfer(1'b1, half);
      byt = {byt[6:0], rx_bit};
      if (k % 8 == 7) check("ncr_filler", byt, 8'hFF);
    end
    for (int k = 0; k < exp_n * 8 && k < max_bits; k++) begin
      xfer(1'b1, half);
      byt = {byt[6:0], rx_bit};
      if (k % 8 == 7) begin
        got_b[k / 8] = byt;
        check("resp_byte", byt, exp_b[k / 8]);
      end
    end
  endtask

  task automatic txn(input logic [5:0] idx, input logic [31:0] arg, input bit zero_crc, input int trail);
    int half;
    half = $urandom_range(4, 6);
    send_frame(idx, arg, zero_crc, half);
    read_resp(half, 1000);
    for (int k = 0; k < trail; k++) begin
      xfer(1'b1, half);
      check("trail_do", rx_bit, 1'b1);
    end
  endtask

  task automatic model_reset();
    m_idle  = 1'b1;
    m_polls = 0;
    m_app   = 1'b0;
    c_idle  = 1'b1;
    c_idx   = 6'd0;
    c_arg   = 32'd0;
    evq.delete();
  endtask

  task automatic get_ready();
    for (int r = 0; r <= POLLS; r++) begin
      txn(6'd55, 32'd0, 1'b0, 2);
      txn(6'd41, 32'h0010_0000, 1'b0, 2);
    end
  endtask

  // Per-cycle comparison of strobe, latched fields, idle flag and deselected DO.
  always @(negedge clk) begin
    if (!rst_n) begin
      cs_hi_cnt = 0;
    end else begin
      cs_hi_cnt = CS ? cs_hi_cnt + 1 : 0;
      if (cmdStrobe) begin
        n_strobes++;
        if (evq.size() == 0) begin
          check("unexpected_strobe", 1'b1, 1'b0);
        end else begin
          ev = evq.pop_front();
          check("strobe_index", cmdIndex, ev.idx);
          check("strobe_arg", cmdArgument, ev.arg);
          check("strobe_idle", isIdle, ev.idle);
          c_idle = ev.idle;
          c_idx  = ev.idx;
          c_arg  = ev.arg;
        end
      end else begin
        check("idle_hold", isIdle, c_idle);
        check("index_hold", cmdIndex, c_idx);
        check("arg_hold", cmdArgument, c_arg);
      end
      if (cs_hi_cnt >= 4) check("do_deselected", DO, 1'b1);
    end
  end

  initial begin
    int          s0;
    logic [5:0]  ri;
    logic [31:0] ra;

    repeat (3) @(posedge clk);
    #3;
    check("rst_do", DO, 1'b1);
    check("rst_idle", isIdle, 1'b1);
    check("rst_strobe", cmdStrobe, 1'b0);
    check("rst_index", cmdIndex, 6'd0);
    check("rst_arg", cmdArgument, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #3;

    check("lit_crc_cmd0", ref_crc7(40'h40_0000_0000), 7'h4A);
    check("lit_crc_cmd8", ref_crc7(40'h48_0000_01AA), 7'h43);
    check("lit_crc_cmd55", ref_crc7(40'h77_0000_0000), 7'h32);

    cs_low();
    txn(6'd0, 32'd0, 1'b0, 8);
    check("lit_cmd0_r1", got_b[0], 8'h01);
    txn(6'd8, 32'h0000_01AA, 1'b0, 8);
    check("lit_cmd8_r7", {got_b[0], got_b[1], got_b[2], got_b[3], got_b[4]}, 40'h01_0000_01AA);
    check("lit_cmd8_echo", {got_b[3][3:0], got_b[4]}, 12'h1AA);
    for (int r = 0; r < 3; r++) begin
      txn(6'd55, 32'd0, 1'b0, 2);
      check("lit_cmd55_r1", got_b[0], 8'h01);
      txn(6'd41, 32'h0010_0000, 1'b0, 2);
      check("lit_acmd41_r1", got_b[0], (r == 2) ? 8'h00 : 8'h01);
    end
    check("lit_ready_idle", isIdle, 1'b0);
    txn(6'd55, 32'd0, 1'b0, 0);
    check("lit_cmd55_ready", got_b[0], 8'h00);

    txn(6'd0, 32'd0, 1'b0, 0);
    txn(6'd41, 32'h0010_0000, 1'b0, 1);
    check("lit_cmd41_noapp", got_b[0], 8'h05);
    txn(6'd17, 32'h0000_0200, 1'b0, 1);
    check("lit_cmd17_idle", got_b[0], 8'h05);
    get_ready();
    txn(6'd17, 32'h0000_0400, 1'b0, 1);
    check("lit_cmd17_ready", got_b[0], 8'h04);

    // deselect after 20 bits: frame discarded, next CMD0 strobes once
    s0 = n_strobes;
    send_bits(mk_frame(6'd0, 32'd0, 1'b0), 20, 5);
    cs_high();
    cs_low();
    txn(6'd0, 32'd0, 1'b0, 4);
    check("lit_abort_r1", got_b[0], 8'h01);
    check("abort_strobes", n_strobes - s0, 1);

    // deselect in the middle of a response
    send_frame(6'd0, 32'd0, 1'b0, 5);
    read_resp(5, 3);
    CS = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("cs_abort_do", DO, 1'b1);
    #2;
    cs_high();
    cs_low();

    // asynchronous reset in the middle of a CMD8 response
    get_ready();
    send_frame(6'd8, 32'h0000_03C5, 1'b0, 5);
    read_resp(5, 4);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("areset_do", DO, 1'b1);
    check("areset_idle", isIdle, 1'b1);
    check("areset_index", cmdIndex, 6'd0);
    check("areset_arg", cmdArgument, 32'd0);
    CS = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    cs_low();

    // CMD8 with a zero CRC field
    txn(6'd0, 32'd0, 1'b0, 2);
    txn(6'd8, 32'h0000_01AA, 1'b1, 2);
    check("lit_cmd8_badcrc", got_b[0], CRC_EN ? 8'h09 : 8'h01);
    check("lit_badcrc_idle", isIdle, 1'b1);

    // randomised command traffic
    for (int n = 0; n < 25; n++) begin
      case ($urandom_range(0, 7))
        0:       ri = 6'd0;
        1:       ri = 6'd8;
        2, 3:    ri = 6'd55;
        4, 5:    ri = 6'd41;
        6:       ri = 6'd17;
        default: ri = 6'($urandom_range(0, 63));
      endcase
      ra = $urandom;
      txn(ri, ra, $urandom_range(0, 5) == 0, $urandom_range(0, 8));
      if ($urandom_range(0, 3) == 0) begin
        cs_high();
        cs_low();
      end
    end

    repeat (10) @(posedge clk);
    #3;
    check("pending_frames", evq.size(), 0);
    check("strobe_total", n_strobes, n_frames);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
